// File: rtl/uart_rx_os16_pkg.sv
// Shared definitions for the 16x-oversampling UART receiver: FSM state encoding and
// the oversample counter values at which the line is sampled.
package uart_rx_os16_pkg;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    // Start bit is checked half a bit after the falling edge; later bits one full bit apart.
    localparam logic [3:0] OS_MID_START = 4'd7;
    localparam logic [3:0] OS_MID_BIT   = 4'd15;

endpackage

// File: rtl/uart_rx_os16_sync_ff.sv
// Multi-flop synchroniser for an asynchronous single-bit input; all flops reset to RST_VAL.
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RST_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx_os16.sv
// UART receiver driven by a 16x baud enable, with a one-entry valid/ready holding register.
// Optional parity bit and parity_err port are built when UART_RX_PARITY_EN is defined.
module uart_rx_os16
    import uart_rx_os16_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2,
    parameter int PARITY_ODD  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxclk_en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 overrun
);

    logic                 rx_s;
    rx_state_t            state, state_nxt;
    logic [3:0]           os_cnt, os_cnt_nxt;
    logic [3:0]           bit_cnt, bit_cnt_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic                 stop_sample;
    logic                 deliver;
    logic                 hold_blocked;
`ifdef UART_RX_PARITY_EN
    localparam logic PAR_ODD = 1'(PARITY_ODD);
    logic par_bad, par_bad_nxt;
`endif

    sync_ff #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RX_IDLE;
            os_cnt  <= 4'd0;
            bit_cnt <= 4'd0;
            shreg   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            os_cnt  <= os_cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
            shreg   <= shreg_nxt;
`ifdef UART_RX_PARITY_EN
            par_bad <= par_bad_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        os_cnt_nxt  = os_cnt;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        stop_sample = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_nxt = par_bad;
`endif
        if (rxclk_en) begin
            case (state)
                RX_IDLE: begin
                    if (!rx_s) begin
                        state_nxt  = RX_START;
                        os_cnt_nxt = 4'd0;
                    end
                end
                RX_START: begin
                    if (os_cnt == OS_MID_START) begin
                        os_cnt_nxt  = 4'd0;
                        bit_cnt_nxt = 4'd0;
                        state_nxt   = rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        os_cnt_nxt = os_cnt + 4'd1;
                    end
                end
                RX_DATA: begin
                    os_cnt_nxt = os_cnt + 4'd1;
                    if (os_cnt == OS_MID_BIT) begin
                        // LSB arrives first, so shifting right leaves it at bit 0 at the end
                        shreg_nxt   = {rx_s, shreg[DATA_BITS-1:1]};
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        if (bit_cnt == 4'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_nxt = RX_PARITY;
`else
                            state_nxt = RX_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                RX_PARITY: begin
                    os_cnt_nxt = os_cnt + 4'd1;
                    if (os_cnt == OS_MID_BIT) begin
                        par_bad_nxt = (^shreg) ^ rx_s ^ PAR_ODD;
                        state_nxt   = RX_STOP;
                    end
                end
`endif
                RX_STOP: begin
                    os_cnt_nxt = os_cnt + 4'd1;
                    if (os_cnt == OS_MID_BIT) begin
                        // Back to IDLE mid stop bit so an immediately following start edge is seen
                        stop_sample = 1'b1;
                        state_nxt   = RX_IDLE;
                    end
                end
                default: state_nxt = RX_IDLE;
            endcase
        end
    end

    assign deliver      = stop_sample & rx_s;
    assign hold_blocked = rx_valid & ~rx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err  <= stop_sample & ~rx_s;
            overrun    <= deliver & hold_blocked;
`ifdef UART_RX_PARITY_EN
            parity_err <= deliver & par_bad;
`endif
            // A pop in the same cycle as a delivery frees the slot for the new byte
            if (deliver && !hold_blocked) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed and randomized bench for uart_rx_os16: serial frames built from the frame format,
// expected bytes and error counts tracked in queues/counters inside the bench.
module tb_uart_rx_os16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxclk_en = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    int n_ferr = 0;
    int n_ovr = 0;
    int n_perr = 0;
    int n_vclk = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int seen = 0;

    uart_rx_os16 #(
        .DATA_BITS   (8),
        .SYNC_STAGES (2),
        .PARITY_ODD  (0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rxclk_en   (rxclk_en),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // 16x enable as a 1-in-4 clk pulse, so one bit is 64 clk
    int unsigned div = 0;
    always @(negedge clk) begin
        div = (div + 1) % 4;
        rxclk_en = (div == 0);
    end

    always @(negedge clk) begin
        if (rx_valid) n_vclk++;
        if (rx_valid && rx_ready) got.push_back(rx_data);
        if (frame_err) n_ferr++;
        if (overrun) n_ovr++;
`ifdef UART_RX_PARITY_EN
        if (parity_err) n_perr++;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_rx(input string tag);
        check({tag, "_count"}, got.size(), exp_q.size());
        for (int i = seen; i < exp_q.size(); i++) begin
            if (i < got.size()) check({tag, "_byte"}, {24'd0, got[i]}, {24'd0, exp_q[i]});
        end
        seen = exp_q.size();
    endtask

    task automatic bit_time(input logic b);
        rx = b;
        repeat (64) @(negedge clk);
    endtask

    task automatic idle(input int nbits);
        rx = 1'b1;
        repeat (64 * nbits) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input bit use_par, input logic par_bit);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(d[i]);
        if (use_par) bit_time(par_bit);
        bit_time(stop_bit);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 rx_ready = v;
    endtask

    initial begin
        int f0, o0, v0, p0, ferr_exp;
        logic [7:0] d;
        bit bad;

        rx_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_valid", rx_valid, 0);
        check("reset_data", rx_data, 0);
        check("reset_ferr", frame_err, 0);
        check("reset_ovr", overrun, 0);
        rst_n = 1'b1;
        idle(1);

        // Single byte with consumer always ready
        v0 = n_vclk;
        send_frame(8'hA5, 1'b1, 0, 1'b0);
        exp_q.push_back(8'hA5);
        idle(1);
        check_rx("t1");
        check("t1_valid_clks", n_vclk - v0, 1);
        check("t1_ferr", n_ferr, 0);
        check("t1_ovr", n_ovr, 0);

        // Low pulse shorter than half a bit is rejected at the start-bit midpoint
        v0 = n_vclk;
        rx = 1'b0;
        repeat (20) @(negedge clk);
        idle(2);
        check("t2_glitch_valid", n_vclk - v0, 0);
        check("t2_glitch_ferr", n_ferr, 0);
        send_frame(8'h3C, 1'b1, 0, 1'b0);
        exp_q.push_back(8'h3C);
        idle(1);
        check_rx("t2");

        // Bad stop bit, then a good frame
        v0 = n_vclk;
        send_frame(8'h55, 1'b0, 0, 1'b0);
        idle(2);
        check("t3_ferr", n_ferr, 1);
        check("t3_no_valid", n_vclk - v0, 0);
        send_frame(8'h0F, 1'b1, 0, 1'b0);
        exp_q.push_back(8'h0F);
        idle(1);
        check_rx("t3");

        // Overrun: second byte arrives while the first is still held
        set_ready(1'b0);
        send_frame(8'h11, 1'b1, 0, 1'b0);
        idle(1);
        check("t4_valid_held", rx_valid, 1);
        check("t4_data_held", rx_data, 8'h11);
        send_frame(8'h22, 1'b1, 0, 1'b0);
        idle(1);
        check("t4_ovr", n_ovr, 1);
        check("t4_data_kept", rx_data, 8'h11);
        set_ready(1'b1);
        set_ready(1'b0);
        exp_q.push_back(8'h11);
        @(negedge clk);
        check("t4_valid_popped", rx_valid, 0);
        check("t4_data_after_pop", rx_data, 8'h11);
        check_rx("t4");

        // Back-to-back frames with no idle gap, then random frames
        set_ready(1'b1);
        @(negedge clk);
        o0 = n_ovr;
        send_frame(8'h00, 1'b1, 0, 1'b0);
        send_frame(8'hFF, 1'b1, 0, 1'b0);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        idle(1);
        check_rx("t5_b2b");
        f0 = n_ferr;
        ferr_exp = 0;
        for (int k = 0; k < 8; k++) begin
            d = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 3) == 0);
            send_frame(d, !bad, 0, 1'b0);
            if (bad) begin
                ferr_exp++;
                idle(2);
            end else begin
                exp_q.push_back(d);
                if ($urandom_range(0, 1) == 1) idle(1);
            end
        end
        idle(2);
        check_rx("t5_rand");
        check("t5_rand_ferr", n_ferr - f0, ferr_exp);
        check("t5_ovr", n_ovr - o0, 0);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones so the parity bit is 1
        p0 = n_perr;
        send_frame(8'h07, 1'b1, 1, ^8'h07);
        exp_q.push_back(8'h07);
        idle(1);
        check("t6_par_ok", n_perr - p0, 0);
        send_frame(8'h07, 1'b1, 1, ~(^8'h07));
        exp_q.push_back(8'h07);
        idle(1);
        check("t6_par_bad", n_perr - p0, 1);
        check_rx("t6");
`else
        p0 = n_perr;
        check("t6_no_perr", n_perr - p0, 0);
`endif

        // Reset in the middle of a frame while a byte is held
        set_ready(1'b0);
        send_frame(8'h5A, 1'b1, 0, 1'b0);
        idle(1);
        check("t7_held_before_rst", rx_valid, 1);
        rx = 1'b0;
        repeat (64 * 4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t7_rst_valid", rx_valid, 0);
        check("t7_rst_data", rx_data, 0);
        check("t7_rst_ferr", frame_err, 0);
        check("t7_rst_ovr", overrun, 0);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        set_ready(1'b1);
        @(negedge clk);
        f0 = n_ferr;
        send_frame(8'h96, 1'b1, 0, 1'b0);
        exp_q.push_back(8'h96);
        idle(1);
        check_rx("t7");
        check("t7_ferr", n_ferr - f0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
